// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL control/status bundle between the reset sequencer and the PLL wrapper
interface pll_reset_sequencer_if;
   logic       pll_locked;
   logic       restart;
   logic       pll_areset;
   logic       rst_out;
   logic       ready;
   logic       fail;
   logic [3:0] retry_count;

   modport master (
      input  pll_locked,
      input  restart,
      output pll_areset,
      output rst_out,
      output ready,
      output fail,
      output retry_count
   );

   modport slave (
      output pll_locked,
      output restart,
      input  pll_areset,
      input  rst_out,
      input  ready,
      input  fail,
      input  retry_count
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL areset pulse, lock wait with bounded retries, lock settle, downstream reset release
// Optional macro LOCK_LOSS_RESTART_EN: lock loss while in RUN restarts the whole sequence.
module pll_reset_sequencer #(
   parameter int ARESET_CYCLES = 10,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int SETTLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input logic                   inclk0,
   input logic                   areset,
   pll_reset_sequencer_if.master bus
);

   localparam int MAX_AT = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P  = (MAX_AT > SETTLE_CYCLES) ? MAX_AT : SETTLE_CYCLES;
   localparam int CW     = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] ARESET_LAST  = CW'(ARESET_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK cycle that first sees lock counts as the first settle cycle.
   localparam logic [CW-1:0] SETTLE_LAST  = CW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
   localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] count, count_n;
   logic [3:0]    retry, retry_n;
   logic          sync1, locked_s;

   logic pll_areset_q, rst_out_q, ready_q, fail_q;
   logic pll_areset_n, rst_out_n, ready_n, fail_n;

   always_ff @(posedge inclk0 or posedge areset) begin
      if (areset) begin
         state        <= RESET_PLL;
         count        <= '0;
         retry        <= '0;
         sync1        <= 1'b0;
         locked_s     <= 1'b0;
         pll_areset_q <= 1'b1;
         rst_out_q    <= 1'b1;
         ready_q      <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state        <= state_n;
         count        <= count_n;
         retry        <= retry_n;
         sync1        <= bus.pll_locked;
         locked_s     <= sync1;
         pll_areset_q <= pll_areset_n;
         rst_out_q    <= rst_out_n;
         ready_q      <= ready_n;
         fail_q       <= fail_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      retry_n = retry;

      case (state)
         RESET_PLL: begin
            if (count == ARESET_LAST) state_n = WAIT_LOCK;
            else                      count_n = count + CW'(1);
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_n = (SETTLE_CYCLES > 1) ? SETTLE : RUN;
            end else if (count == TIMEOUT_LAST) begin
               if (retry >= RETRY_MAX) begin
                  state_n = FAIL;
               end else begin
                  retry_n = retry + 4'd1;
                  state_n = RESET_PLL;
               end
            end else begin
               count_n = count + CW'(1);
            end
         end
         SETTLE: begin
            if (!locked_s)                 state_n = WAIT_LOCK;
            else if (count == SETTLE_LAST) state_n = RUN;
            else                           count_n = count + CW'(1);
         end
         RUN: begin
`ifdef LOCK_LOSS_RESTART_EN
            if (!locked_s) begin
               state_n = RESET_PLL;
               retry_n = '0;
            end
`else
            state_n = RUN;
`endif
         end
         FAIL: state_n = FAIL;
         default: state_n = RESET_PLL;
      endcase

      if (bus.restart) begin
         state_n = RESET_PLL;
         retry_n = '0;
      end

      if ((state_n != state) || bus.restart) count_n = '0;

      // Outputs are decoded from the next state so they register on the same edge as the state.
      pll_areset_n = (state_n == RESET_PLL) || (state_n == FAIL);
      rst_out_n    = (state_n != RUN);
      ready_n      = (state_n == RUN);
      fail_n       = (state_n == FAIL);
   end

   assign bus.pll_areset  = pll_areset_q;
   assign bus.rst_out     = rst_out_q;
   assign bus.ready       = ready_q;
   assign bus.fail        = fail_q;
   assign bus.retry_count = retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed bench for pll_reset_sequencer with ARESET=4, TIMEOUT=16, SETTLE=8, RETRIES=2
module tb_pll_reset_sequencer;

   logic inclk0 = 1'b0;
   logic areset;
   int   checks = 0;
   int   errors = 0;

   pll_reset_sequencer_if bus ();

   pll_reset_sequencer #(
      .ARESET_CYCLES(4),
      .LOCK_TIMEOUT (16),
      .SETTLE_CYCLES(8),
      .MAX_RETRIES  (2)
   ) dut (
      .inclk0(inclk0),
      .areset(areset),
      .bus   (bus)
   );

   always #5 inclk0 = ~inclk0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got pa/ro/rdy/fail/retry=%b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge inclk0);
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {bus.pll_areset, bus.rst_out, bus.ready, bus.fail, bus.retry_count};
   endfunction

   function automatic logic [7:0] st(input logic pa, input logic ro, input logic rd,
                                     input logic fl, input logic [3:0] rc);
      return {pa, ro, rd, fl, rc};
   endfunction

   initial begin
      areset         = 1'b1;
      bus.pll_locked = 1'b0;
      bus.restart    = 1'b0;
      tick(2);
      check("reset_state", outs(), st(1, 1, 0, 0, 0));

      // Normal lock
      areset = 1'b0;
      tick(3); check("s1_areset_held", outs(), st(1, 1, 0, 0, 0));
      tick(1); check("s1_areset_fall", outs(), st(0, 1, 0, 0, 0));
      tick(5); bus.pll_locked = 1'b1;
      tick(9); check("s1_not_yet", outs(), st(0, 1, 0, 0, 0));
      tick(1); check("s1_run", outs(), st(0, 0, 1, 0, 0));

      // Settle glitch, after one lock timeout so retry_count is non-zero
      bus.restart = 1'b1; bus.pll_locked = 1'b0;
      tick(1); bus.restart = 1'b0;
      check("s3_restart", outs(), st(1, 1, 0, 0, 0));
      tick(4);  check("s3_wait", outs(), st(0, 1, 0, 0, 0));
      tick(15); check("s3_pre_timeout", outs(), st(0, 1, 0, 0, 0));
      tick(1);  check("s3_timeout", outs(), st(1, 1, 0, 0, 1));
      tick(4);  check("s3_wait2", outs(), st(0, 1, 0, 0, 1));
      bus.pll_locked = 1'b1;
      tick(5); bus.pll_locked = 1'b0;
      tick(1); bus.pll_locked = 1'b1;
      check("s3_glitch", outs(), st(0, 1, 0, 0, 1));
      for (int i = 2; i <= 10; i++) begin
         tick(1);
         check("s3_no_release", outs(), st(0, 1, 0, 0, 1));
      end
      tick(1); check("s3_run", outs(), st(0, 0, 1, 0, 1));

      // Lock loss in RUN
      bus.pll_locked = 1'b0;
`ifdef LOCK_LOSS_RESTART_EN
      tick(2); check("s4_still_run", outs(), st(0, 0, 1, 0, 1));
      tick(1); check("s4_lock_loss", outs(), st(1, 1, 0, 0, 0));
      bus.pll_locked = 1'b1;
      tick(3); check("s4_areset_held", outs(), st(1, 1, 0, 0, 0));
      tick(1); check("s4_areset_fall", outs(), st(0, 1, 0, 0, 0));
      tick(7); check("s4_settling", outs(), st(0, 1, 0, 0, 0));
      tick(1); check("s4_relock_run", outs(), st(0, 0, 1, 0, 0));
`else
      tick(3);  check("s4_ignored", outs(), st(0, 0, 1, 0, 1));
      tick(10); check("s4_ignored_late", outs(), st(0, 0, 1, 0, 1));
      bus.pll_locked = 1'b1;
      tick(3);
`endif

      // Never lock: three 4-cycle pulses with 16-cycle gaps, then FAIL
      bus.pll_locked = 1'b0; bus.restart = 1'b1;
      tick(1); bus.restart = 1'b0;
      for (int t = 0; t < 70; t++) begin
         if (t > 0) tick(1);
         if (t < 60)
            check("s2_retry_seq", outs(), st((t % 20) < 4, 1, 0, 0, 4'(t / 20)));
         else
            check("s2_fail", outs(), st(1, 1, 0, 1, 2));
      end

      // Restart from FAIL
      bus.restart = 1'b1;
      tick(1); bus.restart = 1'b0;
      check("s5_restart", outs(), st(1, 1, 0, 0, 0));
      tick(3); check("s5_areset_held", outs(), st(1, 1, 0, 0, 0));
      tick(1); check("s5_areset_fall", outs(), st(0, 1, 0, 0, 0));
      bus.pll_locked = 1'b1;
      tick(9); check("s5_not_yet", outs(), st(0, 1, 0, 0, 0));
      tick(1); check("s5_run", outs(), st(0, 0, 1, 0, 0));

      // Asynchronous reset while in SETTLE
      bus.restart = 1'b1;
      tick(1); bus.restart = 1'b0;
      tick(6); check("s6_settle", outs(), st(0, 1, 0, 0, 0));
      #3 areset = 1'b1;
      #1 check("s6_async", outs(), st(1, 1, 0, 0, 0));
      tick(2); check("s6_held", outs(), st(1, 1, 0, 0, 0));
      areset = 1'b0;
      tick(3); check("s6_areset_held", outs(), st(1, 1, 0, 0, 0));
      tick(1); check("s6_areset_fall", outs(), st(0, 1, 0, 0, 0));
      tick(7); check("s6_settling", outs(), st(0, 1, 0, 0, 0));
      tick(1); check("s6_run", outs(), st(0, 0, 1, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
